// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: moves the snake one cell per step tick on a 16x16 grid.
// A tick counter paces the moves. Each move picks a direction, checks the
// grid edge (STEP), then checks the body and food (CHECK). A legal move
// shifts the body by one segment.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start                 level: IDLE -> RUN, OVER -> IDLE
//   stage                 level: 1 = running, 0 = paused (counter holds)
//   Up/Down/Left/Right    latched direction requests (priority U>D>L>R)
//   food_x, food_y        current food cell
//   seg_idx               renderer read index
//   seg_x, seg_y          combinational read of segment seg_idx (0 = head)
//   length                current body length
//   ate, step_done        one-cycle pulses on a committed move
//   game_over, win        level flags, held in OVER
module snake_move_ctrl #(
    parameter int TICK_DIV = 12_500_000,
    parameter int MAX_LEN  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stage,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    input  logic [3:0] food_x,
    input  logic [3:0] food_y,
    input  logic [3:0] seg_idx,
    output logic [3:0] seg_x,
    output logic [3:0] seg_y,
    output logic [4:0] length,
    output logic       ate,
    output logic       step_done,
    output logic       game_over,
    output logic       win
);
    localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]      LEN_MAX = 5'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_CHECK, S_OVER} state_t;
    // Encoding puts opposite directions one bit0 flip apart.
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } coord_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    dir_t             cur_dir, req_dir, key_dir;
    logic             key_any;
    coord_t           seg [MAX_LEN];
    coord_t           next_head, step_head, rd_seg;
    logic             off_grid, collide, food_hit, win_now, do_init;
    logic [MAX_LEN-1:0] hit;

    // Direction request: ignore empty requests and reversals.
    always_comb begin
        key_any = Up | Down | Left | Right;
        key_dir = D_RIGHT;
        if (Up)        key_dir = D_UP;
        else if (Down) key_dir = D_DOWN;
        else if (Left) key_dir = D_LEFT;
        req_dir = cur_dir;
        if (key_any && (key_dir != dir_t'(cur_dir ^ 2'b01)))
            req_dir = key_dir;
    end

    // Candidate head; off_grid flags a move past the 0/15 edges.
    always_comb begin
        step_head = seg[0];
        off_grid  = 1'b0;
        case (req_dir)
            D_UP:    if (seg[0].y == 4'd0)  off_grid = 1'b1; else step_head.y = seg[0].y - 4'd1;
            D_DOWN:  if (seg[0].y == 4'd15) off_grid = 1'b1; else step_head.y = seg[0].y + 4'd1;
            D_LEFT:  if (seg[0].x == 4'd0)  off_grid = 1'b1; else step_head.x = seg[0].x - 4'd1;
            default: if (seg[0].x == 4'd15) off_grid = 1'b1; else step_head.x = seg[0].x + 4'd1;
        endcase
    end

    // Body compare excludes the tail (index length-1): it vacates this move.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_hit
        assign hit[gi] = (5'(gi) + 5'd1 < length) && (seg[gi] == next_head);
    end

    assign collide  = |hit;
    assign food_hit = (next_head == coord_t'{food_x, food_y});
    assign win_now  = food_hit && (length + 5'd1 == LEN_MAX);
    assign do_init  = reset || ((state == S_OVER) && start);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (stage && cnt == CNT_TOP) state_nxt = S_STEP;
            S_STEP:  state_nxt = off_grid ? S_OVER : S_CHECK;
            S_CHECK: state_nxt = (collide || win_now) ? S_OVER : S_RUN;
            S_OVER:  if (start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output pulses
    always_comb begin
        step_done = (state == S_CHECK) && !collide;
        ate       = (state == S_CHECK) && !collide && food_hit;
    end

    // Datapath: counter, direction, body, flags
    always_ff @(posedge clk) begin
        if (do_init) begin
            cnt       <= '0;
            cur_dir   <= D_RIGHT;
            length    <= 5'd3;
            next_head <= '0;
            game_over <= 1'b0;
            win       <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= '0;
            seg[0] <= coord_t'{4'd8, 4'd8};
            seg[1] <= coord_t'{4'd7, 4'd8};
            seg[2] <= coord_t'{4'd6, 4'd8};
        end else begin
            case (state)
                S_IDLE: cnt <= '0;
                S_RUN: if (stage) cnt <= (cnt == CNT_TOP) ? '0 : cnt + 1'b1;
                S_STEP: begin
                    cur_dir <= req_dir;
                    if (off_grid) game_over <= 1'b1;
                    else          next_head <= step_head;
                end
                S_CHECK: begin
                    if (collide) begin
                        game_over <= 1'b1;
                    end else begin
                        for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
                        seg[0] <= next_head;
                        if (food_hit) length <= length + 5'd1;
                        if (win_now)  win <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Renderer read port; indices past MAX_LEN read as (0,0).
    always_comb begin
        rd_seg = '0;
        for (int i = 0; i < MAX_LEN; i++)
            if (seg_idx == 4'(i)) rd_seg = seg[i];
        seg_x = rd_seg.x;
        seg_y = rd_seg.y;
    end
endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl (TICK_DIV=4, MAX_LEN=6).
module tb_snake_move_ctrl;
    logic       clk = 1'b0;
    logic       reset, start, stage, Up, Down, Left, Right;
    logic [3:0] food_x, food_y, seg_idx, seg_x, seg_y;
    logic [4:0] length;
    logic       ate, step_done, game_over, win;

    int n_cmp = 0;
    int n_bad = 0;

    snake_move_ctrl #(.TICK_DIV(4), .MAX_LEN(6)) dut (
        .clk(clk), .reset(reset), .start(start), .stage(stage),
        .Up(Up), .Down(Down), .Left(Left), .Right(Right),
        .food_x(food_x), .food_y(food_y), .seg_idx(seg_idx),
        .seg_x(seg_x), .seg_y(seg_y), .length(length),
        .ate(ate), .step_done(step_done), .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] keys;   // {Up, Down, Left, Right}
        logic [3:0] fx, fy;
        int         ex, ey, elen, eate;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_keys(input logic [3:0] k);
        {Up, Down, Left, Right} = k;
    endtask

    task automatic rd(input int idx, output int x, output int y);
        seg_idx = 4'(idx);
        #1;
        x = int'(seg_x);
        y = int'(seg_y);
    endtask

    // Wait (bounded) for step_done or game_over, sampled on negedges.
    task automatic wait_evt(output int n, output bit sd, output bit at, output bit go);
        n = 0; sd = 0; at = 0; go = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (step_done || game_over) begin
                sd = step_done; at = ate; go = game_over;
                return;
            end
        end
        n = -1;
    endtask

    task automatic step_chk(input string tag, input int ex, input int ey,
                            input int elen, input int eate, output int n);
        int x, y;
        bit sd, at, go;
        wait_evt(n, sd, at, go);
        chk({tag, " step_done"}, int'(sd), 1);
        chk({tag, " ate"}, int'(at), eate);
        chk({tag, " game_over"}, int'(go), 0);
        @(negedge clk);
        rd(0, x, y);
        chk({tag, " head_x"}, x, ex);
        chk({tag, " head_y"}, y, ey);
        chk({tag, " length"}, int'(length), elen);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stage = 1'b0;
        set_keys(4'b0000); food_x = 4'd0; food_y = 4'd0; seg_idx = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        int   x, y, n;
        bit   sd, at, go, saw;

        // Table continues from head (10,8) heading Right, body length 3.
        tbl[0] = '{4'b0010, 4'd0,  4'd0, 11, 8, 3, 0}; // Left reversal ignored
        tbl[1] = '{4'b1000, 4'd0,  4'd0, 11, 7, 3, 0};
        tbl[2] = '{4'b0010, 4'd0,  4'd0, 10, 7, 3, 0};
        tbl[3] = '{4'b0001, 4'd0,  4'd0,  9, 7, 3, 0}; // Right reversal ignored
        tbl[4] = '{4'b0100, 4'd0,  4'd0,  9, 8, 3, 0};
        tbl[5] = '{4'b1000, 4'd0,  4'd0,  9, 9, 3, 0}; // Up reversal ignored
        tbl[6] = '{4'b0001, 4'd10, 4'd9, 10, 9, 4, 1}; // eat
        tbl[7] = '{4'b1010, 4'd0,  4'd0, 10, 8, 4, 0}; // Up beats Left
        tbl[8] = '{4'b0000, 4'd0,  4'd0, 10, 7, 4, 0}; // no key keeps Up

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst length", int'(length), 3);
        rd(0, x, y); chk("rst seg0_x", x, 8); chk("rst seg0_y", y, 8);
        rd(1, x, y); chk("rst seg1_x", x, 7); chk("rst seg1_y", y, 8);
        rd(2, x, y); chk("rst seg2_x", x, 6); chk("rst seg2_y", y, 8);
        rd(3, x, y); chk("rst seg3_x", x, 0); chk("rst seg3_y", y, 0);
        chk("rst game_over", int'(game_over), 0);
        chk("rst win", int'(win), 0);
        chk("rst step_done", int'(step_done), 0);
        chk("rst ate", int'(ate), 0);

        // Step cadence: first step_done 6 cycles after start, then every 6.
        stage = 1'b1;
        do_start();
        wait_evt(n, sd, at, go);
        chk("first step latency", n, 6);
        chk("first step_done", int'(sd), 1);
        @(negedge clk);
        rd(0, x, y); chk("first head_x", x, 9); chk("first head_y", y, 8);
        step_chk("second", 10, 8, 3, 0, n);
        chk("step period", n + 1, 6);

        for (int i = 0; i < 9; i++) begin
            set_keys(tbl[i].keys);
            food_x = tbl[i].fx;
            food_y = tbl[i].fy;
            step_chk($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].elen, tbl[i].eate, n);
            if (i == 6) begin
                rd(3, x, y); chk("vec6 seg3_x", x, 9); chk("vec6 seg3_y", y, 7);
            end
        end

        // Pause: counter holds for 10 cycles and resumes at count 2.
        do_reset();
        stage = 1'b1;
        do_start();
        @(posedge clk);
        #1 stage = 1'b0;
        saw = 0;
        repeat (10) begin @(negedge clk); saw |= step_done; end
        chk("pause no step", int'(saw), 0);
        rd(0, x, y); chk("pause head_x", x, 8);
        stage = 1'b1;
        wait_evt(n, sd, at, go);
        chk("resume latency", n, 4);
        chk("resume step_done", int'(sd), 1);

        // Reset during CHECK: back to IDLE, no move committed, no stepping.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        saw = 0;
        repeat (8) begin @(negedge clk); saw |= step_done | ate; end
        chk("midreset idle", int'(saw), 0);
        rd(0, x, y); chk("midreset head_x", x, 8); chk("midreset head_y", y, 8);
        chk("midreset length", int'(length), 3);

        // Wall: run Right off the grid edge.
        do_reset();
        stage = 1'b1;
        do_start();
        for (int i = 0; i < 7; i++) step_chk($sformatf("wall%0d", i), 9 + i, 8, 3, 0, n);
        wait_evt(n, sd, at, go);
        chk("wall game_over", int'(go), 1);
        chk("wall no step_done", int'(sd), 0);
        rd(0, x, y); chk("wall head_x", x, 15); chk("wall head_y", y, 8);
        rd(1, x, y); chk("wall seg1_x", x, 14);
        chk("wall length", int'(length), 3);
        chk("wall win", int'(win), 0);
        repeat (3) @(negedge clk);
        rd(0, x, y); chk("over frozen head_x", x, 15);
        chk("over frozen game_over", int'(game_over), 1);
        do_start();
        @(negedge clk);
        rd(0, x, y); chk("restart head_x", x, 8); chk("restart head_y", y, 8);
        rd(1, x, y); chk("restart seg1_x", x, 7);
        chk("restart length", int'(length), 3);
        chk("restart game_over", int'(game_over), 0);

        // Eat, loop back onto the tail (legal), then grow to MAX_LEN for a win.
        do_reset();
        stage = 1'b1;
        food_x = 4'd9; food_y = 4'd8;
        do_start();
        step_chk("eat", 9, 8, 4, 1, n);
        rd(3, x, y); chk("eat seg3_x", x, 6); chk("eat seg3_y", y, 8);
        food_x = 4'd0; food_y = 4'd0;
        set_keys(4'b1000); step_chk("loopU", 9, 7, 4, 0, n);
        set_keys(4'b0010); step_chk("loopL", 8, 7, 4, 0, n);
        set_keys(4'b0100); step_chk("tail", 8, 8, 4, 0, n);
        set_keys(4'b0000);
        food_x = 4'd8; food_y = 4'd9;  step_chk("grow5", 8, 9, 5, 1, n);
        food_x = 4'd8; food_y = 4'd10; step_chk("grow6", 8, 10, 6, 1, n);
        chk("win flag", int'(win), 1);
        chk("win game_over", int'(game_over), 0);

        // Body collision: length 5, head turns into segment 3.
        do_reset();
        stage = 1'b1;
        food_x = 4'd9; food_y = 4'd8;
        do_start();
        step_chk("c_eat1", 9, 8, 4, 1, n);
        food_x = 4'd10; food_y = 4'd8;
        step_chk("c_eat2", 10, 8, 5, 1, n);
        food_x = 4'd0; food_y = 4'd0;
        set_keys(4'b1000); step_chk("c_up", 10, 7, 5, 0, n);
        set_keys(4'b0010); step_chk("c_left", 9, 7, 5, 0, n);
        set_keys(4'b0100);
        wait_evt(n, sd, at, go);
        chk("body game_over", int'(go), 1);
        chk("body no step_done", int'(sd), 0);
        rd(0, x, y); chk("body head_x", x, 9); chk("body head_y", y, 7);
        chk("body length", int'(length), 5);
        chk("body win", int'(win), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
